// File: rtl/system_ram_arbiter_if.sv
// Avalon-MM master-side bundle for one requester of the shared system RAM.
// The master modport is the requester's view; the slave modport is the arbiter's view.
interface system_ram_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
);
   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/system_ram_arbiter.sv
// Round-robin two-master arbiter in front of the single-port system RAM.
// Read responses are routed back through a tag pipeline matching the RAM latency.
module system_ram_arbiter #(
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 32,
   parameter int BE_W         = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   system_ram_arbiter_if.slave  m0,
   system_ram_arbiter_if.slave  m1,
   output logic [ADDR_W-1:0]    ram_address,
   output logic [BE_W-1:0]      ram_byteenable,
   output logic                 ram_chipselect,
   output logic                 ram_write,
   output logic [DATA_W-1:0]    ram_writedata,
   output logic                 ram_clken,
   input  logic [DATA_W-1:0]    ram_readdata
);
   logic w_req0;
   logic w_req1;
   logic w_gnt0;
   logic w_gnt1;
   logic w_rd;
   logic r_last;
   logic [READ_LATENCY-1:0] r_tag_v;
   logic [READ_LATENCY-1:0] r_tag_id;

   assign w_req0 = m0.read | m0.write;
   assign w_req1 = m1.read | m1.write;

   // r_last = 1 means m1 was served last, so m0 wins the next tie
   assign w_gnt0 = ~reset & w_req0 & (~w_req1 | r_last);
   assign w_gnt1 = ~reset & w_req1 & (~w_req0 | ~r_last);

   assign w_rd = (w_gnt0 & m0.read & ~m0.write)
               | (w_gnt1 & m1.read & ~m1.write);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last   <= 1'b1;
         r_tag_v  <= '0;
         r_tag_id <= '0;
      end else begin
         if (w_gnt0 | w_gnt1)
            r_last <= w_gnt1;
         r_tag_v  <= (r_tag_v << 1) | READ_LATENCY'(w_rd);
         r_tag_id <= (r_tag_id << 1) | READ_LATENCY'(w_gnt1);
      end
   end

   always_comb begin
      ram_address    = '0;
      ram_byteenable = '0;
      ram_writedata  = '0;
      ram_write      = 1'b0;
      ram_chipselect = 1'b0;
      unique case (1'b1)
         w_gnt0: begin
            ram_address    = m0.address;
            ram_byteenable = m0.byteenable;
            ram_writedata  = m0.writedata;
            ram_write      = m0.write;
            ram_chipselect = 1'b1;
         end
         w_gnt1: begin
            ram_address    = m1.address;
            ram_byteenable = m1.byteenable;
            ram_writedata  = m1.writedata;
            ram_write      = m1.write;
            ram_chipselect = 1'b1;
         end
         default: ;
      endcase
   end

   assign ram_clken = 1'b1;

   assign m0.waitrequest = reset | (w_req0 & ~w_gnt0);
   assign m1.waitrequest = reset | (w_req1 & ~w_gnt1);

   assign m0.readdata = ram_readdata;
   assign m1.readdata = ram_readdata;

   assign m0.readdatavalid = ~reset & r_tag_v[READ_LATENCY-1]
                           & ~r_tag_id[READ_LATENCY-1];
   assign m1.readdatavalid = ~reset & r_tag_v[READ_LATENCY-1]
                           & r_tag_id[READ_LATENCY-1];
endmodule

// File: tb/tb_system_ram_arbiter.sv
// Scoreboard bench for system_ram_arbiter: one instance at latency 1 with a
// byte-enabled RAM model, one at latency 3 with a patterned pipelined RAM.
module tb_system_ram_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   nt = 0;
   int   nf = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   system_ram_arbiter_if a0 ();
   system_ram_arbiter_if a1 ();
   system_ram_arbiter_if b0 ();
   system_ram_arbiter_if b1 ();

   logic [10:0] ra_addr, rb_addr;
   logic [3:0]  ra_be, rb_be;
   logic        ra_cs, rb_cs, ra_wr, rb_wr, ra_ck, rb_ck;
   logic [31:0] ra_wd, rb_wd, ra_rd, rb_rd;

   system_ram_arbiter #(.READ_LATENCY(1)) dut (
      .clk(clk), .reset(reset), .m0(a0.slave), .m1(a1.slave),
      .ram_address(ra_addr), .ram_byteenable(ra_be),
      .ram_chipselect(ra_cs), .ram_write(ra_wr),
      .ram_writedata(ra_wd), .ram_clken(ra_ck),
      .ram_readdata(ra_rd)
   );

   system_ram_arbiter #(.READ_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .m0(b0.slave), .m1(b1.slave),
      .ram_address(rb_addr), .ram_byteenable(rb_be),
      .ram_chipselect(rb_cs), .ram_write(rb_wr),
      .ram_writedata(rb_wd), .ram_clken(rb_ck),
      .ram_readdata(rb_rd)
   );

   function automatic logic [31:0] pat(input logic [10:0] a);
      return {16'hA5A5, 5'd0, a};
   endfunction

   function automatic logic [31:0] pat2(input logic [10:0] a);
      return {16'h5A5A, 5'd0, a};
   endfunction

   // latency-1 RAM model, read-before-write
   logic [31:0] mem [0:1279];
   initial for (int i = 0; i < 1280; i++) mem[i] = pat(11'(i));
   always @(posedge clk) begin
      if (ra_cs && ra_ck) begin
         if (ra_wr) begin
            for (int b = 0; b < 4; b++)
               if (ra_be[b]) mem[ra_addr][8*b +: 8] <= ra_wd[8*b +: 8];
         end else begin
            ra_rd <= mem[ra_addr];
         end
      end
   end

   // latency-3 read-only RAM model
   logic [31:0] p0, p1, p2;
   always @(posedge clk) begin
      p0 <= pat2(rb_addr);
      p1 <= p0;
      p2 <= p1;
   end
   assign rb_rd = p2;

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;
   exp_t q [4][$];

   logic        rv [4];
   logic [31:0] rdat [4];
   assign rv[0] = a0.readdatavalid;
   assign rv[1] = a1.readdatavalid;
   assign rv[2] = b0.readdatavalid;
   assign rv[3] = b1.readdatavalid;
   assign rdat[0] = a0.readdata;
   assign rdat[1] = a1.readdata;
   assign rdat[2] = b0.readdata;
   assign rdat[3] = b1.readdata;

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rv[k] === 1'b1) begin
            nt++;
            if (q[k].size() == 0) begin
               nf++;
               $display("FAIL rvalid_%0d: got unexpected valid data %h at cycle %0d, want none",
                        k, rdat[k], cyc);
            end else begin
               exp_t e;
               e = q[k].pop_front();
               if (rdat[k] !== e.d || cyc != e.c) begin
                  nf++;
                  $display("FAIL rdata_%0d: got %h at cycle %0d, want %h at cycle %0d",
                           k, rdat[k], cyc, e.d, e.c);
               end
            end
         end else if (rv[k] !== 1'b0) begin
            nt++;
            nf++;
            $display("FAIL rvalid_%0d: got %b at cycle %0d, want 0/1", k, rv[k], cyc);
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      nt++;
      if (got !== exp) begin
         nf++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", n, got, exp, cyc);
      end
   endtask

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [10:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } req_t;

   localparam req_t IDLE = '0;

   function automatic req_t RD(input logic [10:0] a);
      return '{rd: 1'b1, wr: 1'b0, a: a, be: 4'hF, d: 32'h0};
   endfunction

   function automatic req_t WR(input logic [10:0] a, input logic [3:0] be,
                               input logic [31:0] d);
      return '{rd: 1'b0, wr: 1'b1, a: a, be: be, d: d};
   endfunction

   task automatic drive(input req_t r0, input req_t r1);
      a0.read = r0.rd; a0.write = r0.wr; a0.address = r0.a;
      a0.byteenable = r0.be; a0.writedata = r0.d;
      a1.read = r1.rd; a1.write = r1.wr; a1.address = r1.a;
      a1.byteenable = r1.be; a1.writedata = r1.d;
   endtask

   // one bus cycle on the latency-1 instance with expected waitrequests
   task automatic step(input req_t r0, input req_t r1,
                       input logic ew0, input logic ew1,
                       input logic [31:0] x0, input logic [31:0] x1);
      logic g0, g1;
      drive(r0, r1);
      @(negedge clk);
      g0 = (r0.rd | r0.wr) & ~ew0;
      g1 = (r1.rd | r1.wr) & ~ew1;
      chk("m0_wait", 32'(a0.waitrequest), 32'(ew0));
      chk("m1_wait", 32'(a1.waitrequest), 32'(ew1));
      chk("ram_cs", 32'(ra_cs), 32'(g0 | g1));
      if (g0) begin
         chk("ram_addr0", 32'(ra_addr), 32'(r0.a));
         chk("ram_wr0", 32'(ra_wr), 32'(r0.wr));
      end
      if (g1) begin
         chk("ram_addr1", 32'(ra_addr), 32'(r1.a));
         chk("ram_wr1", 32'(ra_wr), 32'(r1.wr));
      end
      if (g0 && r0.rd && !r0.wr) q[0].push_back('{x0, cyc + 1});
      if (g1 && r1.rd && !r1.wr) q[1].push_back('{x1, cyc + 1});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(IDLE, IDLE, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // reset with both masters requesting; in-flight reads are expected to vanish
   task automatic do_reset(input int n);
      for (int k = 0; k < 4; k++) q[k].delete();
      reset = 1'b1;
      drive(RD(11'h7), RD(11'h9));
      repeat (n) begin
         @(negedge clk);
         chk("rst_m0_wait", 32'(a0.waitrequest), 32'd1);
         chk("rst_m1_wait", 32'(a1.waitrequest), 32'd1);
         chk("rst_cs", 32'(ra_cs), 32'd0);
         chk("rst_wr", 32'(ra_wr), 32'd0);
         chk("rst_l3_wait", 32'(b0.waitrequest), 32'd1);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      drive(IDLE, IDLE);
   endtask

   initial begin
      logic [10:0] ad;
      drive(IDLE, IDLE);
      b0.read = 0; b0.write = 0; b0.address = '0; b0.byteenable = '0; b0.writedata = '0;
      b1.read = 0; b1.write = 0; b1.address = '0; b1.byteenable = '0; b1.writedata = '0;
      @(posedge clk);
      #1;
      do_reset(2);
      chk("clken", 32'(ra_ck), 32'd1);

      // write then read back on m0
      step(WR(11'h010, 4'hF, 32'hDEADBEEF), IDLE, 1'b0, 1'b0, 32'h0, 32'h0);
      step(RD(11'h010), IDLE, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
      idle(2);

      // read+write together: write wins, no response
      step('{rd: 1'b1, wr: 1'b1, a: 11'h011, be: 4'hF, d: 32'h12345678},
           IDLE, 1'b0, 1'b0, 32'h0, 32'h0);
      step(RD(11'h011), IDLE, 1'b0, 1'b0, 32'h12345678, 32'h0);
      idle(2);

      // first contention after reset goes to m0
      do_reset(1);
      step(RD(11'h020), RD(11'h030), 1'b0, 1'b1, pat(11'h020), 32'h0);
      step(IDLE, RD(11'h030), 1'b0, 1'b0, 32'h0, pat(11'h030));
      idle(2);

      // continuous contention alternates strictly
      for (int i = 0; i < 8; i++) begin
         logic [10:0] x, y;
         x = 11'h100 + 11'((i + 1) / 2);
         y = 11'h200 + 11'(i / 2);
         step(RD(x), RD(y), 1'(i % 2), 1'(1 - i % 2), pat(x), pat(y));
      end
      idle(2);

      // byte-lane merge at the top word
      step(IDLE, WR(11'h4FF, 4'hF, 32'hFFFFFFFF), 1'b0, 1'b0, 32'h0, 32'h0);
      step(IDLE, WR(11'h4FF, 4'h2, 32'h0000AA00), 1'b0, 1'b0, 32'h0, 32'h0);
      step(RD(11'h4FF), IDLE, 1'b0, 1'b0, 32'hFFFFAAFF, 32'h0);
      idle(2);

      // reset right after an m1 read grant drops the response
      step(IDLE, RD(11'h040), 1'b0, 1'b0, 32'h0, pat(11'h040));
      do_reset(2);
      idle(3);

      // latency-3 instance: four back-to-back reads
      for (int i = 0; i < 4; i++) begin
         ad = 11'h300 + 11'(i);
         b0.read = 1'b1;
         b0.address = ad;
         @(negedge clk);
         chk("l3_wait", 32'(b0.waitrequest), 32'd0);
         chk("l3_cs", 32'(rb_cs), 32'd1);
         q[2].push_back('{pat2(ad), cyc + 3});
         @(posedge clk);
         #1;
      end
      b0.read = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      for (int k = 0; k < 4; k++) chk("queue_drained", 32'(q[k].size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", nt, nf);
      $finish;
   end
endmodule
